// File: rtl/keypoint_coord_fifo.sv
// Border/cap filter for centre-aligned corner flags, feeding a 16-deep FWFT coordinate FIFO.
// Write-to-kp_valid latency 1; a write into a full FIFO is dropped unless a read happens in the same cycle.
module keypoint_coord_fifo #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9,
  parameter int BORDER     = 18,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_KP     = 500,
  parameter int KPC_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sof,
  input  logic             delayCorner,
  output logic             kp_valid,
  input  logic             kp_ready,
  output logic [COL_W-1:0] kp_col,
  output logic [ROW_W-1:0] kp_row,
  output logic [KPC_W-1:0] kp_count,
  output logic [7:0]       drop_cnt,
  output logic             overflow,
  output logic             frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(IMG_WIDTH - 1 - BORDER);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(IMG_HEIGHT - 1 - BORDER);
  localparam logic [KPC_W-1:0] KP_MAX   = KPC_W'(MAX_KP);

  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [KPC_W-1:0] kp_count_q, kp_count_d, kp_base;
  logic [7:0]       drop_cnt_q, drop_cnt_d, drop_base;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;

  logic [ADDR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ROW_W+COL_W-1:0]   mem_q [DEPTH];

  logic frame_start, in_border, has_room, accept;
  logic fifo_empty, fifo_full, rd_en, wr_en, drop;

  // sof overrides the counters so the flagged pixel is always (0,0)
  assign frame_start = ena & sof;
  assign cur_row     = frame_start ? '0 : row_q;
  assign cur_col     = frame_start ? '0 : col_q;
  assign kp_base     = frame_start ? '0 : kp_count_q;
  assign drop_base   = frame_start ? '0 : drop_cnt_q;

  assign in_border = (cur_row >= ROW_LO) && (cur_row <= ROW_HI) &&
                     (cur_col >= COL_LO) && (cur_col <= COL_HI);
  assign has_room  = kp_base < KP_MAX;
  assign accept    = ena & delayCorner & in_border & has_room;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign rd_en      = ~fifo_empty & kp_ready;
  assign wr_en      = accept & (~fifo_full | rd_en);
  assign drop       = accept & fifo_full & ~rd_en;

  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    if (ena) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        row_d = cur_row;
        col_d = cur_col + 1'b1;
      end
    end
  end

  always_comb begin
    kp_count_d = kp_base + KPC_W'(wr_en);
    drop_cnt_d = drop_base;
    if (drop && (drop_base != 8'hFF)) begin
      drop_cnt_d = drop_base + 8'd1;
    end
    overflow_d = (frame_start ? 1'b0 : overflow_q) | drop;
    wr_ptr_d   = wr_ptr_q + (ADDR_W+1)'(wr_en);
    rd_ptr_d   = rd_ptr_q + (ADDR_W+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      kp_count_q   <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      kp_count_q   <= kp_count_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {cur_row, cur_col};
    end
  end

  assign kp_valid   = ~fifo_empty;
  assign kp_row     = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]][ROW_W+COL_W-1:COL_W];
  assign kp_col     = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]][COL_W-1:0];
  assign kp_count   = kp_count_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypoint_coord_fifo.sv
// Scoreboard bench for keypoint_coord_fifo on a reduced 64x48 image with a 40-keypoint cap.
module tb_keypoint_coord_fifo;

  localparam int W      = 64;
  localparam int H      = 48;
  localparam int BRD    = 18;
  localparam int DEPTH  = 16;
  localparam int MAXKP  = 40;

  logic       clk = 1'b0;
  logic       rst, ena, sof, delayCorner, kp_ready;
  logic       kp_valid, overflow, frame_done;
  logic [9:0] kp_col, kp_count;
  logic [8:0] kp_row;
  logic [7:0] drop_cnt;

  keypoint_coord_fifo #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_W(10), .ROW_W(9), .BORDER(BRD),
    .DEPTH(DEPTH), .ADDR_W(4), .MAX_KP(MAXKP), .KPC_W(10)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .sof(sof), .delayCorner(delayCorner),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_col(kp_col), .kp_row(kp_row),
    .kp_count(kp_count), .drop_cnt(drop_cnt), .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;

  // Reference model state
  logic [18:0] sb_q[$];
  int m_row = 0, m_col = 0, m_kpc = 0, m_drop = 0;
  bit m_ovf = 0, m_fd = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit in_border(input int r, input int c);
    return (r >= BRD) && (r <= H - 1 - BRD) && (c >= BRD) && (c <= W - 1 - BRD);
  endfunction

  // Called just after a negedge: drive, compare current outputs, advance model, clock once.
  task automatic step(input logic r, input logic e, input logic s, input logic c, input logic k);
    int cr, cc;
    bit rd, full, acc;
    logic [18:0] head;
    rst = r; ena = e; sof = s; delayCorner = c; kp_ready = k;
    #1;
    check_eq("kp_valid", kp_valid, (sb_q.size() != 0));
    check_eq("kp_count", kp_count, m_kpc);
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("overflow", overflow, m_ovf);
    check_eq("frame_done", frame_done, m_fd);
    if (frame_done === 1'b1) fd_seen++;
    if (sb_q.size() != 0) begin
      head = sb_q[0];
      check_eq("kp_row", kp_row, head[18:10]);
      check_eq("kp_col", kp_col, head[9:0]);
    end
    if (r) begin
      sb_q.delete();
      m_row = 0; m_col = 0; m_kpc = 0; m_drop = 0; m_ovf = 0; m_fd = 0;
    end else begin
      rd   = (sb_q.size() != 0) && k;
      full = (sb_q.size() == DEPTH);
      m_fd = 0;
      if (rd) void'(sb_q.pop_front());
      if (e) begin
        cr = s ? 0 : m_row;
        cc = s ? 0 : m_col;
        if (s) begin m_kpc = 0; m_drop = 0; m_ovf = 0; end
        acc = c && in_border(cr, cc) && (m_kpc < MAXKP);
        if (acc) begin
          if (!full || rd) begin
            sb_q.push_back({cr[8:0], cc[9:0]});
            m_kpc++;
          end else begin
            if (m_drop < 255) m_drop++;
            m_ovf = 1;
          end
        end
        if (cc == W - 1) begin
          m_col = 0;
          if (cr == H - 1) begin m_row = 0; m_fd = 1; end
          else m_row = cr + 1;
        end else begin
          m_row = cr; m_col = cc + 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance with no corners until the model's next pixel is (r,c); sprinkles idle cycles.
  task automatic goto_pix(input int r, input int c, input logic k);
    int guard = 0;
    while (!(m_row == r && m_col == c)) begin
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b1, 1'b1, k);
      else step(1'b0, 1'b1, 1'b0, 1'b0, k);
      guard++;
      if (guard > 2 * W * H) begin
        check_eq("goto_timeout", guard, 0);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sof = 1'b0; delayCorner = 1'b0; kp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("rst_kp_row", kp_row, 0);
    check_eq("rst_kp_col", kp_col, 0);

    // Row 0 is inside the border: nothing may be written
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("row0_valid", kp_valid, 0);
    check_eq("row0_count", kp_count, 0);

    // First legal corner
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    goto_pix(18, 18, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("first_valid", kp_valid, 1);
    check_eq("first_row", kp_row, 18);
    check_eq("first_col", kp_col, 18);
    check_eq("first_count", kp_count, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("first_popped", kp_valid, 0);

    // Border edges: only (H-1-BRD, W-1-BRD) is accepted
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    goto_pix(17, 30, 1'b1);     step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    goto_pix(20, 17, 1'b1);     step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    goto_pix(20, W - BRD, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    goto_pix(H - 1 - BRD, W - 1 - BRD, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("edge_count", kp_count, 1);
    check_eq("edge_row", kp_row, H - 1 - BRD);
    check_eq("edge_col", kp_col, W - 1 - BRD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    goto_pix(H - BRD, 30, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("edge_count2", kp_count, 1);

    // Overflow: 20 corners with the consumer stalled
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    goto_pix(20, 20, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("ovf_drop", drop_cnt, 4);
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_count", kp_count, 16);
    // Full FIFO with a read in the same cycle still accepts the write
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("full_rw_drop", drop_cnt, 4);
    check_eq("full_rw_count", kp_count, 17);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sof_drop_clr", drop_cnt, 0);
    check_eq("sof_ovf_clr", overflow, 0);
    check_eq("sof_keeps_fifo", kp_valid, 1);
    repeat (DEPTH) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("drained", kp_valid, 0);

    // Whole frame of corners with a free-running consumer
    fd_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < W * H; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("cap_count", kp_count, MAXKP);
    check_eq("frame_done_once", fd_seen, 1);

    // Reset mid-frame discards queued entries
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    goto_pix(25, 25, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("pre_rst_count", kp_count, 5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("post_rst_valid", kp_valid, 0);
    check_eq("post_rst_count", kp_count, 0);
    check_eq("post_rst_drop", drop_cnt, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
